// File: rtl/demux_lane_scheduler_if.sv
// Byte-stream / lane-strobe bundle between the RX byte source and the
// 1:4 lane demux scheduler.
//   validEntrada, Entrada : input byte stream (source -> scheduler)
//   pause                 : per-lane "do not push" from lane FIFOs
//   data_out, push,
//   lane_sel              : registered byte, one-hot lane strobe, lane index
// Modports: master = byte source / lane side, slave = scheduler.
interface demux_lane_scheduler_if #(
    parameter int DATA_W = 8
);
    logic              validEntrada;
    logic [DATA_W-1:0] Entrada;
    logic [3:0]        pause;
    logic [DATA_W-1:0] data_out;
    logic [3:0]        push;
    logic [1:0]        lane_sel;

    modport master (
        output validEntrada, Entrada, pause,
        input  data_out, push, lane_sel
    );

    modport slave (
        input  validEntrada, Entrada, pause,
        output data_out, push, lane_sel
    );
endinterface

// File: rtl/demux_lane_scheduler.sv
// Lane scheduler for the RX 1:4 byte demux. Each valid input byte is
// assigned to one of four lanes round-robin, honouring per-lane pause.
// After ALIGN_GAP consecutive idle cycles the lane pointer realigns to
// lane 0. Bytes that cannot be placed are dropped and counted.
// Ports:
//   clk_2f    : clock, all state on posedge
//   reset     : synchronous active-high reset
//   bus       : slave side of demux_lane_scheduler_if (byte in, lane out)
//   clr_stats : synchronous clear of drop_cnt
//   drop_cnt  : saturating dropped-byte count
//   state_o   : 0 IDLE, 1 RUN, 2 BLOCKED
// Optional feature macro: DEMUX_SCHED_SKIP_EN -- when defined, a paused
// pointer lane is skipped in favour of the next unpaused lane; otherwise
// strict round-robin (paused pointer lane drops the byte).
module demux_lane_scheduler #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter int ALIGN_GAP = 2
) (
    input  logic                 clk_2f,
    input  logic                 reset,
    demux_lane_scheduler_if.slave bus,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [1:0]           state_o
);
    localparam int GAP_W = (ALIGN_GAP < 2) ? 1 : $clog2(ALIGN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(ALIGN_GAP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    state_t            state_reg;
    logic [1:0]        ptr_reg;
    logic [GAP_W-1:0]  gap_reg;
    logic [DATA_W-1:0] data_reg;
    logic [3:0]        push_reg;
    logic [1:0]        lane_reg;
    logic [CNT_W-1:0]  drop_reg;

    logic              lane_ok;
    logic [1:0]        lane_pick;
    logic [GAP_W-1:0]  gap_next;
    logic              drop_ev;

`ifdef DEMUX_SCHED_SKIP_EN
    // Candidate lanes in scan order starting at the pointer.
    logic [1:0] cand [4];
    logic [3:0] cand_free;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi]      = ptr_reg + 2'(gi);
        assign cand_free[gi] = ~bus.pause[cand[gi]];
    end

    // Iterate from the far end so the nearest free candidate wins.
    always_comb begin
        lane_ok   = 1'b0;
        lane_pick = ptr_reg;
        for (int i = 3; i >= 0; i--) begin
            if (cand_free[i]) begin
                lane_ok   = 1'b1;
                lane_pick = cand[i];
            end
        end
    end
`else
    // Strict order: only the pointer lane may take the byte.
    assign lane_ok   = ~bus.pause[ptr_reg];
    assign lane_pick = ptr_reg;
`endif

    assign drop_ev  = bus.validEntrada & ~lane_ok;
    assign gap_next = (gap_reg == GAP_MAX) ? gap_reg : gap_reg + 1'b1;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            gap_reg   <= '0;
            data_reg  <= '0;
            push_reg  <= '0;
            lane_reg  <= '0;
            drop_reg  <= '0;
        end else begin
            push_reg <= '0;
            if (bus.validEntrada) begin
                // Any valid byte breaks an idle run, placed or not.
                gap_reg <= '0;
                if (lane_ok) begin
                    push_reg  <= 4'b0001 << lane_pick;
                    data_reg  <= bus.Entrada;
                    lane_reg  <= lane_pick;
                    ptr_reg   <= lane_pick + 2'd1;
                    state_reg <= ST_RUN;
                end else begin
                    state_reg <= ST_BLOCKED;
                end
            end else begin
                state_reg <= ST_IDLE;
                gap_reg   <= gap_next;
                if (gap_next == GAP_MAX) begin
                    ptr_reg <= '0;
                end
            end

            // A clear in the same cycle as a drop keeps that drop.
            if (clr_stats) begin
                drop_reg <= drop_ev ? CNT_W'(1) : '0;
            end else if (drop_ev && (drop_reg != '1)) begin
                drop_reg <= drop_reg + 1'b1;
            end
        end
    end

    always_comb begin
        case (state_reg)
            ST_RUN:     state_o = 2'd1;
            ST_BLOCKED: state_o = 2'd2;
            default:    state_o = 2'd0;
        endcase
    end

    assign bus.data_out = data_reg;
    assign bus.push     = push_reg;
    assign bus.lane_sel = lane_reg;
    assign drop_cnt     = drop_reg;
endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Directed bench for demux_lane_scheduler: a table of per-cycle stimulus
// and hand-computed post-edge outputs, then a hand-written drop-counter
// saturation / clear sequence.
module tb_demux_lane_scheduler;
    logic       clk_2f = 1'b0;
    logic       reset  = 1'b1;
    logic       clr_stats = 1'b0;
    logic [7:0] drop_cnt;
    logic [1:0] state_o;

    int tests  = 0;
    int errors = 0;

    demux_lane_scheduler_if #(.DATA_W(8)) bus ();

    demux_lane_scheduler #(.DATA_W(8), .CNT_W(8), .ALIGN_GAP(2)) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .bus       (bus),
        .clr_stats (clr_stats),
        .drop_cnt  (drop_cnt),
        .state_o   (state_o)
    );

    always #5 clk_2f = ~clk_2f;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic [3:0] p;
        logic       clr;
        logic [3:0] e_push;
        logic [7:0] e_data;
        logic [1:0] e_lane;
        logic [7:0] e_drop;
        logic [1:0] e_state;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic setv(input int i, input logic rst, input logic v, input logic [7:0] d,
                        input logic [3:0] p, input logic clr, input logic [3:0] e_push,
                        input logic [7:0] e_data, input logic [1:0] e_lane,
                        input logic [7:0] e_drop, input logic [1:0] e_state);
        vecs[i].rst = rst;  vecs[i].v = v;  vecs[i].d = d;  vecs[i].p = p;
        vecs[i].clr = clr;  vecs[i].e_push = e_push;  vecs[i].e_data = e_data;
        vecs[i].e_lane = e_lane;  vecs[i].e_drop = e_drop;  vecs[i].e_state = e_state;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then sample after it.
    task automatic drive(input logic rst, input logic v, input logic [7:0] d,
                         input logic [3:0] p, input logic clr);
        @(negedge clk_2f);
        reset            = rst;
        bus.validEntrada = v;
        bus.Entrada      = d;
        bus.pause        = p;
        clr_stats        = clr;
        @(posedge clk_2f);
        #1;
    endtask

    initial begin
        bus.validEntrada = 1'b0;
        bus.Entrada      = 8'h00;
        bus.pause        = 4'h0;

        // reset held 3 cycles
        setv(0,  1,0,8'h00,4'h0,0, 4'h0,8'h00,2'd0,8'd0,2'd0);
        setv(1,  1,0,8'h00,4'h0,0, 4'h0,8'h00,2'd0,8'd0,2'd0);
        setv(2,  1,0,8'h00,4'h0,0, 4'h0,8'h00,2'd0,8'd0,2'd0);
        // four bytes across lanes 0..3
        setv(3,  0,1,8'h00,4'h0,0, 4'h1,8'h00,2'd0,8'd0,2'd1);
        setv(4,  0,1,8'h10,4'h0,0, 4'h2,8'h10,2'd1,8'd0,2'd1);
        setv(5,  0,1,8'h02,4'h0,0, 4'h4,8'h02,2'd2,8'd0,2'd1);
        setv(6,  0,1,8'hF0,4'h0,0, 4'h8,8'hF0,2'd3,8'd0,2'd1);
        // three bytes, 2-cycle gap realigns, A8 on lane 0
        setv(7,  0,1,8'hAC,4'h0,0, 4'h1,8'hAC,2'd0,8'd0,2'd1);
        setv(8,  0,1,8'hDB,4'h0,0, 4'h2,8'hDB,2'd1,8'd0,2'd1);
        setv(9,  0,1,8'h29,4'h0,0, 4'h4,8'h29,2'd2,8'd0,2'd1);
        setv(10, 0,0,8'h00,4'h0,0, 4'h0,8'h29,2'd2,8'd0,2'd0);
        setv(11, 0,0,8'h00,4'h0,0, 4'h0,8'h29,2'd2,8'd0,2'd0);
        setv(12, 0,1,8'hA8,4'h0,0, 4'h1,8'hA8,2'd0,8'd0,2'd1);
        // 1-cycle gap: no realign
        setv(13, 0,1,8'h11,4'h0,0, 4'h2,8'h11,2'd1,8'd0,2'd1);
        setv(14, 0,0,8'h00,4'h0,0, 4'h0,8'h11,2'd1,8'd0,2'd0);
        setv(15, 0,1,8'h22,4'h0,0, 4'h4,8'h22,2'd2,8'd0,2'd1);
        // bring ptr to 1
        setv(16, 0,1,8'h33,4'h0,0, 4'h8,8'h33,2'd3,8'd0,2'd1);
        setv(17, 0,1,8'h44,4'h0,0, 4'h1,8'h44,2'd0,8'd0,2'd1);
`ifdef DEMUX_SCHED_SKIP_EN
        // lane 1 paused: skip to lane 2, ptr -> 3
        setv(18, 0,1,8'hF9,4'h2,0, 4'h4,8'hF9,2'd2,8'd0,2'd1);
        setv(19, 0,1,8'h55,4'h0,0, 4'h8,8'h55,2'd3,8'd0,2'd1);
        setv(20, 0,0,8'h00,4'h0,1, 4'h0,8'h55,2'd3,8'd0,2'd0);
        setv(21, 0,1,8'h61,4'hF,0, 4'h0,8'h55,2'd3,8'd1,2'd2);
        setv(22, 0,1,8'h62,4'hF,0, 4'h0,8'h55,2'd3,8'd2,2'd2);
        setv(23, 0,1,8'h63,4'hF,0, 4'h0,8'h55,2'd3,8'd3,2'd2);
        setv(24, 0,1,8'h77,4'h0,0, 4'h1,8'h77,2'd0,8'd3,2'd1);
        setv(25, 0,1,8'h75,4'h0,0, 4'h2,8'h75,2'd1,8'd3,2'd1);
`else
        // lane 1 paused: byte dropped, ptr stays 1
        setv(18, 0,1,8'hF9,4'h2,0, 4'h0,8'h44,2'd0,8'd1,2'd2);
        setv(19, 0,1,8'h55,4'h0,0, 4'h2,8'h55,2'd1,8'd1,2'd1);
        // clr_stats alone clears the count
        setv(20, 0,0,8'h00,4'h0,1, 4'h0,8'h55,2'd1,8'd0,2'd0);
        setv(21, 0,1,8'h61,4'hF,0, 4'h0,8'h55,2'd1,8'd1,2'd2);
        setv(22, 0,1,8'h62,4'hF,0, 4'h0,8'h55,2'd1,8'd2,2'd2);
        setv(23, 0,1,8'h63,4'hF,0, 4'h0,8'h55,2'd1,8'd3,2'd2);
        setv(24, 0,1,8'h77,4'h0,0, 4'h4,8'h77,2'd2,8'd3,2'd1);
        setv(25, 0,1,8'h75,4'h0,0, 4'h8,8'h75,2'd3,8'd3,2'd1);
`endif
        // reset mid-stream discards the byte presented with it
        setv(26, 1,1,8'h99,4'h0,0, 4'h0,8'h00,2'd0,8'd0,2'd0);
        setv(27, 0,1,8'h88,4'h0,0, 4'h1,8'h88,2'd0,8'd0,2'd1);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].clr);
            $display("[TB] vec %0d: push=%b data=%h lane=%0d drop=%0d state=%0d",
                     i, bus.push, bus.data_out, bus.lane_sel, drop_cnt, state_o);
            chk("push",  i, 32'(bus.push),     32'(vecs[i].e_push));
            chk("data",  i, 32'(bus.data_out), 32'(vecs[i].e_data));
            chk("lane",  i, 32'(bus.lane_sel), 32'(vecs[i].e_lane));
            chk("drop",  i, 32'(drop_cnt),     32'(vecs[i].e_drop));
            chk("state", i, 32'(state_o),      32'(vecs[i].e_state));
        end

        // Drop counter saturation and clear-with-drop.
        for (int i = 0; i < 255; i++) begin
            drive(1'b0, 1'b1, 8'(i), 4'hF, 1'b0);
            if (bus.push != 4'h0) chk("sat_push", i, 32'(bus.push), 32'h0);
        end
        $display("[TB] 255 drops: drop=%h state=%0d", drop_cnt, state_o);
        chk("sat_ff",    100, 32'(drop_cnt), 32'hFF);
        chk("sat_state", 100, 32'(state_o),  32'd2);
        drive(1'b0, 1'b1, 8'hEE, 4'hF, 1'b0);
        $display("[TB] 256th drop: drop=%h push=%b", drop_cnt, bus.push);
        chk("sat_hold",  101, 32'(drop_cnt), 32'hFF);
        chk("sat_push",  101, 32'(bus.push), 32'h0);
        drive(1'b0, 1'b1, 8'hED, 4'hF, 1'b1);
        $display("[TB] clr+drop: drop=%h", drop_cnt);
        chk("clr_drop",  102, 32'(drop_cnt), 32'h01);
        drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        $display("[TB] clr alone: drop=%h state=%0d", drop_cnt, state_o);
        chk("clr_only",  103, 32'(drop_cnt), 32'h00);
        chk("idle",      103, 32'(state_o),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
